serial_packer: RTL and testbench

Parametrised narrow-to-wide packer: collects `RATIO` consecutive `IN_W`-bit beats into one `IN_W*RATIO`-bit word on a single clock. It is the next generation of the 8b→32b gatherer in the byte-striping datapath. Over that gatherer it adds:
- configurable width and lane order;
- ready/valid backpressure on both sides;
- a registered output stage;
- partial-word flush with a lane count;
- selectable gap policy with error reporting.

---
 rtl/serial_packer.sv | 110 +++++++++++
 tb/tb_serial_packer.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/serial_packer.sv
// serial_packer: gathers RATIO consecutive IN_W-bit beats into one IN_W*RATIO-bit
// word, with ready/valid on both sides, a registered output stage, partial-word
// flush reporting the number of valid lanes, and an optional abort-on-gap policy.
//
// Ports:
//   clk_4f     in   1             sole clock, rising edge
//   reset_L    in   1             asynchronous active-low reset
//   data_in    in   IN_W          input beat
//   valid_in   in   1             beat present
//   ready_out  out  1             packer can take a beat this cycle (combinational)
//   flush      in   1             level request to emit the pending partial word
//   data_out   out  IN_W*RATIO    packed word
//   valid_out  out  1             data_out valid
//   ready_in   in   1             downstream accepts data_out this cycle
//   lanes_out  out  CW            number of valid lanes in data_out
//   gap_err    out  1             one-cycle pulse: partial word discarded on a gap
module serial_packer #(
    parameter int unsigned IN_W         = 8,
    parameter int unsigned RATIO        = 4,
    parameter bit          LSB_FIRST    = 1'b0,
    parameter bit          ABORT_ON_GAP = 1'b1
) (
    input  logic                          clk_4f,
    input  logic                          reset_L,
    input  logic [IN_W-1:0]               data_in,
    input  logic                          valid_in,
    output logic                          ready_out,
    input  logic                          flush,
    output logic [IN_W*RATIO-1:0]         data_out,
    output logic                          valid_out,
    input  logic                          ready_in,
    output logic [$clog2(RATIO+1)-1:0]    lanes_out,
    output logic                          gap_err
);

    localparam int unsigned OW = IN_W * RATIO;
    localparam int unsigned CW = $clog2(RATIO + 1);
    localparam logic [CW-1:0] LAST_LANE = CW'(RATIO - 1);
    localparam logic [CW-1:0] FULL_CNT  = CW'(RATIO);

    logic [CW-1:0] cnt;
    logic [OW-1:0] asm_q;

    logic          load_ok;
    logic          acc;
    logic          last_beat;
    logic          flush_go;
    logic          gap;
    logic [CW-1:0] pend;
    logic [CW-1:0] lane;
    logic [OW-1:0] asm_nxt;

    // Handshake, flush/gap decisions and the assembly word with this cycle's beat merged
    always_comb begin
        load_ok   = !valid_out || ready_in;
        ready_out = (cnt != LAST_LANE) || load_ok;
        acc       = valid_in && ready_out;
        last_beat = acc && (cnt == LAST_LANE);
        pend      = cnt + CW'(acc);
        // A beat that completes the word makes any flush redundant
        flush_go  = flush && load_ok && (pend != '0) && !last_beat;
        gap       = ABORT_ON_GAP && !valid_in && (cnt != '0) && !flush_go;
        lane      = LSB_FIRST ? cnt : (LAST_LANE - cnt);
        asm_nxt   = asm_q;
        for (int unsigned i = 0; i < RATIO; i++) begin
            if (acc && (lane == CW'(i))) begin
                asm_nxt[i*IN_W +: IN_W] = data_in;
            end
        end
    end

    // Lane counter, assembly register and registered output stage
    always_ff @(posedge clk_4f or negedge reset_L) begin
        if (!reset_L) begin
            cnt       <= '0;
            asm_q     <= '0;
            data_out  <= '0;
            lanes_out <= '0;
            valid_out <= 1'b0;
            gap_err   <= 1'b0;
        end else begin
            gap_err <= gap;
            if (last_beat) begin
                data_out  <= asm_nxt;
                lanes_out <= FULL_CNT;
                valid_out <= 1'b1;
                cnt       <= '0;
                asm_q     <= '0;
            end else if (flush_go) begin
                data_out  <= asm_nxt;
                lanes_out <= pend;
                valid_out <= 1'b1;
                cnt       <= '0;
                asm_q     <= '0;
            end else begin
                if (ready_in) begin
                    valid_out <= 1'b0;
                end
                if (gap) begin
                    cnt   <= '0;
                    asm_q <= '0;
                end else if (acc) begin
                    cnt   <= cnt + CW'(1);
                    asm_q <= asm_nxt;
                end
            end
        end
    end

endmodule

// File: tb/tb_serial_packer.sv
// Testbench for serial_packer: four instances (default, LSB-first, gap-tolerant,
// and a 4-bit x 3 variant) checked against a queue of expected output words.
module tb_serial_packer;

    logic clk_4f = 1'b0;
    always #5 clk_4f = ~clk_4f;

    // Shared stimulus for the three 8-bit x 4 instances
    logic       rst_n;
    logic [7:0] data_in;
    logic       valid_in;
    logic       flush;
    logic       ready_in;

    logic        ready_out_a, valid_out_a, gap_err_a;
    logic [31:0] data_out_a;
    logic [2:0]  lanes_out_a;
    logic        ready_out_b, valid_out_b, gap_err_b;
    logic [31:0] data_out_b;
    logic [2:0]  lanes_out_b;
    logic        ready_out_c, valid_out_c, gap_err_c;
    logic [31:0] data_out_c;
    logic [2:0]  lanes_out_c;

    // Stimulus for the 4-bit x 3 instance
    logic        rst_d;
    logic [3:0]  din_d;
    logic        vin_d;
    logic        flush_d;
    logic        rin_d;
    logic        ready_out_d, valid_out_d, gap_err_d;
    logic [11:0] data_out_d;
    logic [1:0]  lanes_out_d;

    serial_packer #(.IN_W(8), .RATIO(4), .LSB_FIRST(1'b0), .ABORT_ON_GAP(1'b1)) dut_a (
        .clk_4f(clk_4f), .reset_L(rst_n), .data_in(data_in), .valid_in(valid_in),
        .ready_out(ready_out_a), .flush(flush), .data_out(data_out_a),
        .valid_out(valid_out_a), .ready_in(ready_in), .lanes_out(lanes_out_a),
        .gap_err(gap_err_a));

    serial_packer #(.IN_W(8), .RATIO(4), .LSB_FIRST(1'b1), .ABORT_ON_GAP(1'b1)) dut_b (
        .clk_4f(clk_4f), .reset_L(rst_n), .data_in(data_in), .valid_in(valid_in),
        .ready_out(ready_out_b), .flush(flush), .data_out(data_out_b),
        .valid_out(valid_out_b), .ready_in(ready_in), .lanes_out(lanes_out_b),
        .gap_err(gap_err_b));

    serial_packer #(.IN_W(8), .RATIO(4), .LSB_FIRST(1'b0), .ABORT_ON_GAP(1'b0)) dut_c (
        .clk_4f(clk_4f), .reset_L(rst_n), .data_in(data_in), .valid_in(valid_in),
        .ready_out(ready_out_c), .flush(flush), .data_out(data_out_c),
        .valid_out(valid_out_c), .ready_in(ready_in), .lanes_out(lanes_out_c),
        .gap_err(gap_err_c));

    serial_packer #(.IN_W(4), .RATIO(3), .LSB_FIRST(1'b0), .ABORT_ON_GAP(1'b1)) dut_d (
        .clk_4f(clk_4f), .reset_L(rst_d), .data_in(din_d), .valid_in(vin_d),
        .ready_out(ready_out_d), .flush(flush_d), .data_out(data_out_d),
        .valid_out(valid_out_d), .ready_in(rin_d), .lanes_out(lanes_out_d),
        .gap_err(gap_err_d));

    // Uniform views of the four output ports for the scoreboard
    logic [31:0] obs_data [4];
    logic [3:0]  obs_lanes[4];
    logic        obs_valid[4];
    logic        obs_rdy  [4];

    always_comb begin
        obs_data[0] = data_out_a;          obs_lanes[0] = 4'(lanes_out_a);
        obs_data[1] = data_out_b;          obs_lanes[1] = 4'(lanes_out_b);
        obs_data[2] = data_out_c;          obs_lanes[2] = 4'(lanes_out_c);
        obs_data[3] = 32'(data_out_d);     obs_lanes[3] = 4'(lanes_out_d);
        obs_valid[0] = valid_out_a;        obs_rdy[0] = ready_in;
        obs_valid[1] = valid_out_b;        obs_rdy[1] = ready_in;
        obs_valid[2] = valid_out_c;        obs_rdy[2] = ready_in;
        obs_valid[3] = valid_out_d;        obs_rdy[3] = rin_d;
    end

    logic [31:0] exp_q[4][$];
    logic [3:0]  lan_q[4][$];

    int n_vec = 0;
    int n_err = 0;

    task automatic push(input int k, input logic [31:0] d, input logic [3:0] l);
        exp_q[k].push_back(d);
        lan_q[k].push_back(l);
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk_4f);
        #1;
    endtask

    // Scoreboard: every valid output cycle must match the head of its queue;
    // the head retires when the word transfers.
    always @(negedge clk_4f) begin
        for (int k = 0; k < 4; k++) begin
            if (obs_valid[k]) begin
                n_vec++;
                assert (exp_q[k].size() != 0) else begin
                    n_err++;
                    $error("FAIL unexpected_word dut%0d observed=%h expected=none", k, obs_data[k]);
                end
                if (exp_q[k].size() != 0) begin
                    n_vec++;
                    assert (obs_data[k] === exp_q[k][0] && obs_lanes[k] === lan_q[k][0]) else begin
                        n_err++;
                        $error("FAIL word dut%0d observed=%h/%0d expected=%h/%0d",
                               k, obs_data[k], obs_lanes[k], exp_q[k][0], lan_q[k][0]);
                    end
                    if (obs_rdy[k]) begin
                        void'(exp_q[k].pop_front());
                        void'(lan_q[k].pop_front());
                    end
                end
            end
        end
    end

    logic [7:0] beats[8] = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77, 8'h88};
    logic [7:0] bp[4]    = '{8'hA1, 8'hA2, 8'hA3, 8'hA4};
    logic [7:0] gp[6]    = '{8'h01, 8'h02, 8'h00, 8'h10, 8'h11, 8'h12};
    logic [3:0] nib[5]   = '{4'h5, 4'h6, 4'h7, 4'h1, 4'h2};
    logic [3:0] abc[3]   = '{4'hA, 4'hB, 4'hC};

    initial begin
        rst_n = 1'b0; rst_d = 1'b0;
        data_in = '0; valid_in = 1'b0; flush = 1'b0; ready_in = 1'b0;
        din_d = '0; vin_d = 1'b0; flush_d = 1'b0; rin_d = 1'b0;
        #12;
        chk("rst_data_a",  data_out_a, 32'h0);
        chk("rst_valid_a", 32'(valid_out_a), 32'h0);
        chk("rst_lanes_a", 32'(lanes_out_a), 32'h0);
        chk("rst_gap_a",   32'(gap_err_a), 32'h0);
        chk("rst_data_d",  32'(data_out_d), 32'h0);
        tick();
        rst_n = 1'b1; rst_d = 1'b1; ready_in = 1'b1;

        // Continuous input, no bubbles
        push(0, 32'h11223344, 4); push(0, 32'h55667788, 4);
        push(1, 32'h44332211, 4); push(1, 32'h88776655, 4);
        push(2, 32'h11223344, 4); push(2, 32'h55667788, 4);
        for (int i = 0; i < 8; i++) begin
            valid_in = 1'b1; data_in = beats[i];
            tick();
            chk("cont_ready_a", 32'(ready_out_a), 32'h1);
            if (i == 3 || i == 7) chk("cont_valid_a", 32'(valid_out_a), 32'h1);
            if (i == 4) chk("cont_drop_a", 32'(valid_out_a), 32'h0);
        end
        valid_in = 1'b0;
        tick();
        chk("cont_idle_a", 32'(valid_out_a), 32'h0);

        // Backpressure: lanes keep filling until the last one
        push(0, 32'h11223344, 4); push(0, 32'hA1A2A3A4, 4);
        push(1, 32'h44332211, 4); push(1, 32'hA4A3A2A1, 4);
        push(2, 32'h11223344, 4); push(2, 32'hA1A2A3A4, 4);
        for (int i = 0; i < 4; i++) begin
            valid_in = 1'b1; data_in = beats[i];
            tick();
        end
        ready_in = 1'b0;
        for (int i = 0; i < 3; i++) begin
            data_in = bp[i];
            chk("bp_fill_ready_a", 32'(ready_out_a), 32'h1);
            tick();
        end
        data_in = bp[3];
        chk("bp_stall_ready_a", 32'(ready_out_a), 32'h0);
        chk("bp_stall_ready_b", 32'(ready_out_b), 32'h0);
        tick();
        tick();
        chk("bp_hold_data_a", data_out_a, 32'h11223344);
        chk("bp_hold_ready_a", 32'(ready_out_a), 32'h0);
        ready_in = 1'b1;
        tick();
        chk("bp_reload_valid_a", 32'(valid_out_a), 32'h1);
        valid_in = 1'b0;
        tick();

        // Partial flush, then a flush with nothing pending
        push(0, 32'hDEAD0000, 2);
        push(1, 32'h0000ADDE, 2);
        push(2, 32'hDEAD0000, 2);
        valid_in = 1'b1; data_in = 8'hDE; tick();
        data_in = 8'hAD; tick();
        valid_in = 1'b0; flush = 1'b1; tick();
        chk("flush_lanes_a", 32'(lanes_out_a), 32'h2);
        chk("flush_gap_a", 32'(gap_err_a), 32'h0);
        tick();
        chk("flush_empty_a", 32'(valid_out_a), 32'h0);
        flush = 1'b0;
        tick();

        // Gap: abort discards 0x01,0x02; tolerant instance keeps them
        push(0, 32'h10111213, 4);
        push(1, 32'h13121110, 4);
        push(2, 32'h01021011, 4); push(2, 32'h12130000, 2);
        for (int i = 0; i < 6; i++) begin
            valid_in = (i != 2); data_in = gp[i];
            tick();
            if (i == 2) begin
                chk("gap_pulse_a", 32'(gap_err_a), 32'h1);
                chk("gap_pulse_b", 32'(gap_err_b), 32'h1);
                chk("gap_none_c",  32'(gap_err_c), 32'h0);
            end
            if (i == 3) chk("gap_once_a", 32'(gap_err_a), 32'h0);
        end
        valid_in = 1'b1; data_in = 8'h13; tick();
        valid_in = 1'b0; flush = 1'b1; tick();
        flush = 1'b0;
        tick(); tick();
        chk("post_gap_gap_a", 32'(gap_err_a), 32'h0);

        // Reset mid-word on the 4-bit x 3 instance
        push(3, 32'h567, 3);
        for (int i = 0; i < 5; i++) begin
            vin_d = 1'b1; din_d = nib[i];
            tick();
        end
        chk("d_hold_valid", 32'(valid_out_d), 32'h1);
        vin_d = 1'b0; rst_d = 1'b0;
        #1;
        chk("d_rst_data",  32'(data_out_d), 32'h0);
        chk("d_rst_valid", 32'(valid_out_d), 32'h0);
        chk("d_rst_lanes", 32'(lanes_out_d), 32'h0);
        chk("d_rst_gap",   32'(gap_err_d), 32'h0);
        void'(exp_q[3].pop_front());
        void'(lan_q[3].pop_front());
        tick();
        chk("d_rst_gap_late", 32'(gap_err_d), 32'h0);
        rst_d = 1'b1; rin_d = 1'b1;
        push(3, 32'hABC, 3);
        for (int i = 0; i < 3; i++) begin
            vin_d = 1'b1; din_d = abc[i];
            tick();
        end
        vin_d = 1'b0;
        chk("d_word_valid", 32'(valid_out_d), 32'h1);
        tick(); tick(); tick();

        for (int k = 0; k < 4; k++) chk($sformatf("leftover_dut%0d", k), 32'(exp_q[k].size()), 32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
